// File: rtl/hpf_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed HPF state bank.
package hpf_pkg;
   localparam int PROD_OFS = 3;

   typedef enum logic {SW_IDLE = 1'b0, SW_RUN = 1'b1} sweep_state_t;

   // Offset-binary <-> two's complement is the same MSB inversion in both directions.
   function automatic logic [63:0] ofs_flip(input logic [63:0] v, input int w);
      return v ^ (64'd1 << (w - 1));
   endfunction

   function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int w);
      logic signed [63:0] d, hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      d  = a - b;
      if (d > hi) return hi;
      if (d < lo) return lo;
      return d;
   endfunction
endpackage

// File: rtl/hpf_state_bank_if.sv
// Sample-in / result-out bundle of the HPF state bank.
interface hpf_state_bank_if #(
   parameter int NUM_CH = 32,
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int CH_W   = $clog2(NUM_CH)
);
   logic              in_valid;
   logic              in_ready;
   logic [CH_W-1:0]   in_ch;
   logic [DATA_W-1:0] in_sample;
   logic              sw_ref_en;
   logic [DATA_W-1:0] sw_ref;
   logic              hpf_en;
   logic [COEF_W-1:0] coef;
   logic              clr_all;
   logic              out_valid;
   logic [CH_W-1:0]   out_ch;
   logic [DATA_W-1:0] out_data;
   logic              busy;

   modport slave (
      input  in_valid, in_ch, in_sample, sw_ref_en, sw_ref, hpf_en, coef, clr_all,
      output in_ready, out_valid, out_ch, out_data, busy
   );
   modport master (
      output in_valid, in_ch, in_sample, sw_ref_en, sw_ref, hpf_en, coef, clr_all,
      input  in_ready, out_valid, out_ch, out_data, busy
   );
endinterface

// File: rtl/hpf_sat_sub.sv
// Combinational signed a-b, saturated to the W-bit two's-complement range.
module hpf_sat_sub import hpf_pkg::*; #(
   parameter int W = 16
) (
   input  logic signed [W-1:0] i_a,
   input  logic signed [W-1:0] i_b,
   output logic signed [W-1:0] o_d
);
   assign o_d = W'(sat_sub(64'(i_a), 64'(i_b), W));
endmodule

// File: rtl/hpf_state_bank.sv
// One-pole HPF bank sharing a 3-stage pipeline and one multiplier across NUM_CH channels.
// state   | meaning
// SW_IDLE | pipeline accepts samples
// SW_RUN  | clear sweep writing zero to one channel per cycle, in_ready low
module hpf_state_bank import hpf_pkg::*; #(
   parameter int NUM_CH  = 32,
   parameter int DATA_W  = 16,
   parameter int COEF_W  = 16,
   parameter int CH_W    = $clog2(NUM_CH),
   parameter int STATE_W = DATA_W + COEF_W
) (
   input logic               state_clk,
   input logic               reset,
   hpf_state_bank_if.slave   bus
);
   localparam int XW = DATA_W + 2;
   localparam int PW = DATA_W + COEF_W + 4;

   sweep_state_t r_sw_state, w_sw_next;
   logic [CH_W-1:0] r_sw_cnt, w_sw_cnt_next, w_sweep_addr;
   logic w_busy;

   logic [STATE_W-1:0] r_mem [NUM_CH];

   logic signed [DATA_W-1:0] w_s0_tc, w_ref_tc, w_ref_sub, w_s0_x;
   logic [STATE_W-1:0]       w_s0_state;
   logic                     w_accept;

   logic                     r_s1_valid, r_s1_hpf;
   logic [CH_W-1:0]          r_s1_ch;
   logic signed [XW-1:0]     r_s1_x;
   logic [STATE_W-1:0]       r_s1_state, w_s1_state;
   logic [COEF_W-1:0]        r_s1_coef;
   logic signed [XW-1:0]     w_s1_state_hi, w_s1_diff;

   logic                     r_s2_valid, r_s2_hpf;
   logic [CH_W-1:0]          r_s2_ch;
   logic signed [XW-1:0]     r_s2_x, r_s2_diff, w_s2_sel;
   logic [STATE_W-1:0]       r_s2_state, w_s2_new_state;
   logic [COEF_W-1:0]        r_s2_coef;
   logic signed [COEF_W+1:0] w_s2_coef_s;
   logic signed [PW-1:0]     w_s2_prod;
   logic [DATA_W-1:0]        w_s2_out;
   logic                     w_unused;

   logic                     r_out_valid;
   logic [CH_W-1:0]          r_out_ch;
   logic [DATA_W-1:0]        r_out_data;

   always_ff @(posedge state_clk) begin
      if (reset) begin
         r_sw_state <= SW_RUN;
         r_sw_cnt   <= CH_W'(NUM_CH - 1);
      end else begin
         r_sw_state <= w_sw_next;
         r_sw_cnt   <= w_sw_cnt_next;
      end
   end

   always_comb begin
      w_sw_next     = r_sw_state;
      w_sw_cnt_next = r_sw_cnt;
      if (bus.clr_all) begin
         w_sw_next     = SW_RUN;
         w_sw_cnt_next = CH_W'(NUM_CH - 1);
      end else if (r_sw_state == SW_RUN) begin
         if (r_sw_cnt == '0) w_sw_next = SW_IDLE;
         else                w_sw_cnt_next = r_sw_cnt - 1'b1;
      end
   end

   // Down-counter from NUM_CH-1 maps to ascending addresses 0..NUM_CH-1.
   always_comb begin
      w_busy       = (r_sw_state == SW_RUN);
      w_sweep_addr = ~r_sw_cnt;
   end

   assign w_accept = bus.in_valid & ~w_busy;

   assign w_s0_tc  = DATA_W'(ofs_flip(64'(bus.in_sample), DATA_W));
   assign w_ref_tc = DATA_W'(ofs_flip(64'(bus.sw_ref), DATA_W));

   hpf_sat_sub #(.W(DATA_W)) u_ref_sub (.i_a(w_s0_tc), .i_b(w_ref_tc), .o_d(w_ref_sub));

   assign w_s0_x     = bus.sw_ref_en ? w_ref_sub : w_s0_tc;
   assign w_s0_state = (r_s2_valid && r_s2_ch == bus.in_ch) ? w_s2_new_state : r_mem[bus.in_ch];

   assign w_s1_state    = (r_s2_valid && r_s2_ch == r_s1_ch) ? w_s2_new_state : r_s1_state;
   assign w_s1_state_hi = w_s1_state[STATE_W-1 -: XW];

   hpf_sat_sub #(.W(XW)) u_diff_sub (.i_a(r_s1_x), .i_b(w_s1_state_hi), .o_d(w_s1_diff));

   assign w_s2_coef_s    = {1'b0, r_s2_coef, 1'b0};
   assign w_s2_prod      = PW'(r_s2_diff) * PW'(w_s2_coef_s);
   assign w_s2_new_state = r_s2_state + w_s2_prod[STATE_W+PROD_OFS-1:PROD_OFS];
   assign w_s2_sel       = r_s2_hpf ? r_s2_diff : r_s2_x;
   assign w_s2_out       = DATA_W'(ofs_flip(64'(w_s2_sel[XW-1 -: DATA_W]), DATA_W));
   assign w_unused       = ^{w_s2_prod[PW-1:STATE_W+PROD_OFS], w_s2_prod[PROD_OFS-1:0], w_s2_sel[1:0]};

   always_ff @(posedge state_clk) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s2_valid  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_out_data  <= {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         r_s1_valid  <= w_accept;
         r_s2_valid  <= r_s1_valid;
         r_out_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_out_ch   <= r_s2_ch;
            r_out_data <= w_s2_out;
         end
      end
   end

   always_ff @(posedge state_clk) begin
      r_s1_ch    <= bus.in_ch;
      r_s1_x     <= {w_s0_x, 2'b00};
      r_s1_state <= w_s0_state;
      r_s1_coef  <= bus.coef;
      r_s1_hpf   <= bus.hpf_en;
      r_s2_ch    <= r_s1_ch;
      r_s2_x     <= r_s1_x;
      r_s2_diff  <= w_s1_diff;
      r_s2_state <= w_s1_state;
      r_s2_coef  <= r_s1_coef;
      r_s2_hpf   <= r_s1_hpf;
   end

   // The sweep owns the write port; in-flight results still forward, so their
   // updates are logically ordered before the sweep zeroes the same channel.
   always_ff @(posedge state_clk) begin
      if (w_busy)          r_mem[w_sweep_addr] <= '0;
      else if (r_s2_valid) r_mem[r_s2_ch]      <= w_s2_new_state;
   end

   assign bus.in_ready  = ~w_busy;
   assign bus.busy      = w_busy;
   assign bus.out_valid = r_out_valid;
   assign bus.out_ch    = r_out_ch;
   assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_hpf_state_bank.sv
// Scoreboard bench for hpf_state_bank: driver queues expected results, monitor checks outputs.
module tb_hpf_state_bank;
   localparam int NUM_CH = 32;
   localparam int DATA_W = 16;
   localparam int COEF_W = 16;
   localparam int CH_W   = $clog2(NUM_CH);

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic state_clk = 1'b0;
   logic reset     = 1'b1;
   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_mis = 0;
   int   n_busy;

   hpf_state_bank_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .COEF_W(COEF_W)) bif ();

   hpf_state_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
      .state_clk (state_clk),
      .reset     (reset),
      .bus       (bif)
   );

   always #5 state_clk = ~state_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   always @(negedge state_clk) begin
      if (bif.out_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL unexpected_out: got ch=%0d data=%h, expected no output", bif.out_ch, bif.out_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (bif.out_ch !== mon_e.ch || bif.out_data !== mon_e.data) begin
               n_mis++;
               $display("FAIL result: got ch=%0d data=%h, expected ch=%0d data=%h",
                        bif.out_ch, bif.out_data, mon_e.ch, mon_e.data);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge state_clk);
         #1;
      end
   endtask

   // Transfers one sample; when chk is set the expected result is queued.
   task automatic send(input int ch, input logic [15:0] smp, input logic [15:0] cf, input bit en,
                       input bit ren, input logic [15:0] rf, input logic [15:0] exp, input bit chk);
      int guard;
      exp_t e;
      guard         = 0;
      bif.in_valid  = 1'b1;
      bif.in_ch     = ch[CH_W-1:0];
      bif.in_sample = smp;
      bif.coef      = cf;
      bif.hpf_en    = en;
      bif.sw_ref_en = ren;
      bif.sw_ref    = rf;
      while (!bif.in_ready && guard < 200) begin
         @(posedge state_clk);
         #1;
         guard++;
      end
      check("in_ready_wait", 32'(bif.in_ready), 32'd1);
      if (bif.in_ready) begin
         @(posedge state_clk);
         if (chk) begin
            e.ch   = ch[CH_W-1:0];
            e.data = exp;
            exp_q.push_back(e);
         end
         #1;
      end
      bif.in_valid = 1'b0;
   endtask

   task automatic sendc(input int ch, input logic [15:0] smp, input logic [15:0] cf,
                        input bit en, input logic [15:0] exp);
      send(ch, smp, cf, en, 1'b0, 16'h0000, exp, 1'b1);
   endtask

   task automatic wait_sweep(output int n);
      n = 0;
      while (bif.busy && n < 200) begin
         @(posedge state_clk);
         #1;
         n++;
      end
   endtask

   task automatic pulse_clr;
      bif.clr_all = 1'b1;
      @(posedge state_clk);
      #1;
      bif.clr_all = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bif.in_valid  = 1'b0;
      bif.in_ch     = '0;
      bif.in_sample = '0;
      bif.sw_ref_en = 1'b0;
      bif.sw_ref    = '0;
      bif.hpf_en    = 1'b0;
      bif.coef      = '0;
      bif.clr_all   = 1'b0;

      idle(3);
      check("rst_out_valid", 32'(bif.out_valid), 32'd0);
      check("rst_out_ch",    32'(bif.out_ch),    32'd0);
      check("rst_out_data",  32'(bif.out_data),  32'h8000);
      check("rst_busy",      32'(bif.busy),      32'd1);
      check("rst_in_ready",  32'(bif.in_ready),  32'd0);
      reset = 1'b0;
      wait_sweep(n_busy);
      check("reset_sweep_len", n_busy, NUM_CH);
      check("ready_after_sweep", 32'(bif.in_ready), 32'd1);

      sendc(0,  16'h9000, 16'h0000, 1'b1, 16'h9000);
      sendc(7,  16'h9000, 16'h0000, 1'b1, 16'h9000);
      sendc(31, 16'h9000, 16'h0000, 1'b1, 16'h9000);
      idle(4);

      sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hC000);
      idle(4);
      sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hB000);
      idle(4);

      for (int ord = 0; ord < 5; ord++) begin
         pulse_clr();
         wait_sweep(n_busy);
         check("clr_sweep_len", n_busy, NUM_CH);
         case (ord)
            0: begin
               sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hC000);
               sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hB000);
            end
            1: begin
               sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hC000);
               idle(1);
               sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hB000);
            end
            2: begin
               sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hC000);
               sendc(6, 16'h8000, 16'h4000, 1'b1, 16'h8000);
               sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hB000);
            end
            3: begin
               sendc(6, 16'h8000, 16'h4000, 1'b1, 16'h8000);
               sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hC000);
               sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hB000);
               sendc(6, 16'h8000, 16'h4000, 1'b1, 16'h8000);
            end
            default: begin
               sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hC000);
               sendc(6, 16'h8000, 16'h4000, 1'b1, 16'h8000);
               idle(1);
               sendc(5, 16'hC000, 16'h4000, 1'b1, 16'hB000);
            end
         endcase
         idle(4);
      end

      send(9, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b1);
      send(9, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
      send(9, 16'h9000, 16'h0000, 1'b0, 1'b1, 16'h8800, 16'h8800, 1'b1);
      idle(4);

      // Bypass still updates state: two updates leave state at 0x7000 (18-bit), diff = 0x9000.
      sendc(1, 16'hC000, 16'h4000, 1'b0, 16'hC000);
      sendc(1, 16'hC000, 16'h4000, 1'b0, 16'hC000);
      sendc(1, 16'hC000, 16'h4000, 1'b1, 16'hA400);
      idle(4);

      sendc(3, 16'hC000, 16'h4000, 1'b1, 16'hC000);
      sendc(3, 16'hC000, 16'h4000, 1'b1, 16'hB000);
      bif.clr_all = 1'b1;
      sendc(3, 16'hC000, 16'h4000, 1'b1, 16'hA400);
      bif.clr_all = 1'b0;
      wait_sweep(n_busy);
      check("inflight_clr_sweep_len", n_busy, NUM_CH);
      sendc(3, 16'h9000, 16'h0000, 1'b1, 16'h9000);
      sendc(5, 16'h9000, 16'h0000, 1'b1, 16'h9000);
      sendc(1, 16'h9000, 16'h0000, 1'b1, 16'h9000);
      idle(4);

      pulse_clr();
      idle(10);
      pulse_clr();
      wait_sweep(n_busy);
      check("clr_restart_len", n_busy, NUM_CH);

      send(2, 16'hC000, 16'h4000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      send(2, 16'hC000, 16'h4000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      reset = 1'b1;
      idle(1);
      check("rst_full_out_valid", 32'(bif.out_valid), 32'd0);
      check("rst_full_busy",      32'(bif.busy),      32'd1);
      idle(1);
      check("rst_full_out_valid2", 32'(bif.out_valid), 32'd0);
      reset = 1'b0;
      wait_sweep(n_busy);
      check("rst_full_sweep_len", n_busy, NUM_CH);
      sendc(2, 16'h9000, 16'h0000, 1'b1, 16'h9000);
      idle(4);

      pulse_clr();
      idle(10);
      reset = 1'b1;
      idle(1);
      check("rst_mid_out_valid", 32'(bif.out_valid), 32'd0);
      check("rst_mid_in_ready",  32'(bif.in_ready),  32'd0);
      reset = 1'b0;
      wait_sweep(n_busy);
      check("rst_mid_sweep_len", n_busy, NUM_CH);
      sendc(4, 16'h9000, 16'h0000, 1'b1, 16'h9000);
      idle(5);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
